// File: rtl/stack_pkg.sv
// Shared encodings for the call/return stack sequencer.
// Pop order, FSM state and last-grant types.
package stack_pkg;

  localparam logic POP_LIFO = 1'b0;
  localparam logic POP_FIFO = 1'b1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  typedef enum logic {
    GNT_PUSH = 1'b0,
    GNT_POP  = 1'b1
  } gnt_t;

endpackage

// File: rtl/shift_stack_mem.sv
// DEPTH x WIDTH shift stack; entry 0 is the newest.
// Ports: clk, rst, clr, push/lifo_pop/fifo_pop strobes,
// push_data in; count, head (entry 0), tail (entry count-1) out.
module shift_stack_mem #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             lifo_pop,
  input  logic             fifo_pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] tail
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] tail_idx;

  assign tail_idx = count - CNT_W'(1);
  assign head     = mem[0];

  always_comb begin
    tail = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) == tail_idx) tail = mem[i];
    end
  end

  // Strobes are one-hot by construction
  // (at most one grant per cycle).
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      count <= '0;
    end else begin
      unique case (1'b1)
        push: begin
          mem[0] <= push_data;
          for (int i = 1; i < DEPTH; i++)
            mem[i] <= mem[i-1];
          count <= count + CNT_W'(1);
        end
        lifo_pop: begin
          for (int i = 0; i < DEPTH - 1; i++)
            mem[i] <= mem[i+1];
          mem[DEPTH-1] <= '0;
          count <= count - CNT_W'(1);
        end
        fifo_pop: begin
          for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) == tail_idx) mem[i] <= '0;
          end
          count <= count - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/stack_seq_ctrl.sv
// Push/pop arbiter, RUN/HALT FSM and error flags for the call stack.
// Ports: push/pop handshakes, flush, err_clr; count/full/empty, errs, halted.
module stack_seq_ctrl
  import stack_pkg::*;
#(
  parameter  int WIDTH      = 8,
  parameter  int DEPTH      = 4,
  parameter  bit STICKY_ERR = 1'b1,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_req,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_gnt,
  input  logic             pop_req,
  input  logic             pop_mode,
  output logic             pop_gnt,
  output logic             pop_valid,
  output logic [WIDTH-1:0] pop_data,
  input  logic             flush,
  input  logic             err_clr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             ovf_err,
  output logic             unf_err,
  output logic             halted
);

  state_t           state_q, state_d;
  gnt_t             last_gnt;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             run;
  logic             legal_push, legal_pop;
  logic             ovf_ev, unf_ev;
  logic [WIDTH-1:0] head, tail;

  assign full       = count == CNT_W'(DEPTH);
  assign empty      = count == '0;
  assign run        = (state_q == ST_RUN) && !rst && !flush;
  assign legal_push = push_req && !full;
  assign legal_pop  = pop_req && !empty;
  assign ovf_ev     = run && push_req && full;
  assign unf_ev     = run && pop_req && empty;
  assign ovf_err    = ovf_q | ovf_ev;
  assign unf_err    = unf_q | unf_ev;
  assign halted     = state_q == ST_HALT;

  // Ties go to whichever side was not granted last.
  always_comb begin
    push_gnt = 1'b0;
    pop_gnt  = 1'b0;
    if (run) begin
      if (legal_push && legal_pop) begin
        push_gnt = last_gnt == GNT_POP;
        pop_gnt  = last_gnt == GNT_PUSH;
      end else begin
        push_gnt = legal_push;
        pop_gnt  = legal_pop;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    unique case (state_q)
      ST_RUN: begin
        if (STICKY_ERR && (ovf_ev || unf_ev)) begin
          state_d = ST_HALT;
          ovf_d   = ovf_q | ovf_ev;
          unf_d   = unf_q | unf_ev;
        end
      end
      ST_HALT: begin
        if (err_clr) begin
          state_d = ST_RUN;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      last_gnt <= GNT_POP;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      if (push_gnt)
        last_gnt <= GNT_PUSH;
      else if (pop_gnt)
        last_gnt <= GNT_POP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pop_valid <= 1'b0;
      pop_data  <= '0;
    end else begin
      pop_valid <= pop_gnt;
      if (pop_gnt)
        pop_data <= (pop_mode == POP_FIFO) ? tail : head;
    end
  end

  shift_stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .push      (push_gnt),
    .lifo_pop  (pop_gnt && pop_mode == POP_LIFO),
    .fifo_pop  (pop_gnt && pop_mode == POP_FIFO),
    .push_data (push_data),
    .count     (count),
    .head      (head),
    .tail      (tail)
  );

endmodule

// File: tb/tb_stack_seq_ctrl.sv
// Randomized self-checking bench for stack_seq_ctrl.
// Queue-based reference model; sticky and non-sticky instances.
module tb_stack_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       push_req, pop_req, pop_mode, flush, err_clr;
  logic [7:0] push_data;
  logic       push_gnt, pop_gnt, pop_valid;
  logic [7:0] pop_data;
  logic [2:0] count;
  logic       full, empty, ovf_err, unf_err, halted;

  logic       z_push_req, z_pop_req, z_pop_mode, z_flush, z_err_clr;
  logic [7:0] z_push_data;
  logic       z_push_gnt, z_pop_gnt, z_pop_valid;
  logic [7:0] z_pop_data;
  logic [2:0] z_count;
  logic       z_full, z_empty, z_ovf_err, z_unf_err, z_halted;

  int checks = 0;
  int fails  = 0;

  logic [7:0] mq [$];
  bit         m_last_pop;
  logic [7:0] m_data;

  always #5 clk = ~clk;

  stack_seq_ctrl #(.WIDTH(8), .DEPTH(4), .STICKY_ERR(1'b1)) dut (
    .clk(clk), .rst(rst),
    .push_req(push_req), .push_data(push_data), .push_gnt(push_gnt),
    .pop_req(pop_req), .pop_mode(pop_mode), .pop_gnt(pop_gnt),
    .pop_valid(pop_valid), .pop_data(pop_data),
    .flush(flush), .err_clr(err_clr), .count(count),
    .full(full), .empty(empty), .ovf_err(ovf_err),
    .unf_err(unf_err), .halted(halted)
  );

  stack_seq_ctrl #(.WIDTH(8), .DEPTH(4), .STICKY_ERR(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .push_req(z_push_req), .push_data(z_push_data), .push_gnt(z_push_gnt),
    .pop_req(z_pop_req), .pop_mode(z_pop_mode), .pop_gnt(z_pop_gnt),
    .pop_valid(z_pop_valid), .pop_data(z_pop_data),
    .flush(z_flush), .err_clr(z_err_clr), .count(z_count),
    .full(z_full), .empty(z_empty), .ovf_err(z_ovf_err),
    .unf_err(z_unf_err), .halted(z_halted)
  );

  // Reference: mq[0] is newest; LIFO takes the front, FIFO the back.
  task automatic model_step(input bit pr, input logic [7:0] pd,
                            input bit qr, input bit qm,
                            output bit epg, output bit eqg);
    bit lp, lq;
    lp  = pr && mq.size() < 4;
    lq  = qr && mq.size() > 0;
    epg = 1'b0;
    eqg = 1'b0;
    if (lp && lq) begin
      if (m_last_pop) epg = 1'b1;
      else            eqg = 1'b1;
    end else begin
      epg = lp;
      eqg = lq;
    end
    if (epg) begin
      mq.push_front(pd);
      m_last_pop = 1'b0;
    end
    if (eqg) begin
      m_data = qm ? mq.pop_back() : mq.pop_front();
      m_last_pop = 1'b1;
    end
  endtask

  task automatic drive(input bit pr, input logic [7:0] pd,
                       input bit qr, input bit qm,
                       output bit pg, output bit qg);
    @(negedge clk);
    push_req  = pr;
    push_data = pd;
    pop_req   = qr;
    pop_mode  = qm;
    #1;
    pg = push_gnt;
    qg = pop_gnt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bit pg, qg;
    rst = 1'b1;
    flush = 1'b0; err_clr = 1'b0;
    z_push_req = 1'b0; z_pop_req = 1'b0; z_pop_mode = 1'b0;
    z_push_data = 8'h00; z_flush = 1'b0; z_err_clr = 1'b0;
    drive(0, 8'h00, 0, 0, pg, qg);
    rst = 1'b0;
    mq.delete();
    m_last_pop = 1'b1;
    m_data = 8'h00;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin
      fails++;
      $display("FAIL reset_occ count=%0d empty=%0b full=%0b exp 0/1/0",
               count, empty, full);
    end
    checks++;
    if (pop_valid !== 1'b0 || pop_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_pop valid=%0b data=%h exp 0/00",
               pop_valid, pop_data);
    end
    checks++;
    if (halted !== 1'b0 || ovf_err !== 1'b0 || unf_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_err halted=%0b ovf=%0b unf=%0b exp 0",
               halted, ovf_err, unf_err);
    end
  endtask

  // Runs a list of operations on the sticky instance against the model.
  task automatic run_ops(input string tag, input bit pr[$],
                         input logic [7:0] pd[$], input bit qr[$],
                         input bit qm[$]);
    bit pg, qg, epg, eqg;
    for (int i = 0; i < pr.size(); i++) begin
      model_step(pr[i], pd[i], qr[i], qm[i], epg, eqg);
      drive(pr[i], pd[i], qr[i], qm[i], pg, qg);
      checks++;
      if (pg !== epg || qg !== eqg) begin
        fails++;
        $display("FAIL %s_gnt op%0d got=%0b%0b exp=%0b%0b",
                 tag, i, pg, qg, epg, eqg);
      end
      checks++;
      if (pop_valid !== eqg || pop_data !== m_data) begin
        fails++;
        $display("FAIL %s_pop op%0d got=%0b/%h exp=%0b/%h",
                 tag, i, pop_valid, pop_data, eqg, m_data);
      end
      checks++;
      if (count !== 3'(mq.size()) || full !== (mq.size() == 4)
          || empty !== (mq.size() == 0)) begin
        fails++;
        $display("FAIL %s_cnt op%0d got=%0d exp=%0d",
                 tag, i, count, mq.size());
      end
    end
  endtask

  task automatic test_lifo();
    do_reset();
    run_ops("lifo",
            '{1, 1, 1, 1, 0, 0, 0, 0, 0},
            '{8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 0, 0, 0},
            '{0, 0, 0, 0, 1, 1, 1, 1, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0});
  endtask

  task automatic test_fifo();
    do_reset();
    run_ops("fifo",
            '{1, 1, 1, 0, 0, 0},
            '{8'hA1, 8'hA2, 8'hA3, 0, 0, 0},
            '{0, 0, 0, 1, 1, 1},
            '{0, 0, 0, 1, 1, 0});
  endtask

  // Fill 3 then pop 1 so the last grant is a pop; ties start with push.
  task automatic test_back_to_back();
    do_reset();
    run_ops("rr",
            '{1, 1, 1, 0, 1, 1, 1, 1, 0},
            '{8'hB1, 8'hB2, 8'hB3, 0, 8'hC1, 8'hC1, 8'hC2, 8'hC2, 0},
            '{0, 0, 0, 1, 1, 1, 1, 1, 0},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0});
  endtask

  task automatic test_overflow_halt();
    bit pg, qg;
    do_reset();
    run_ops("ovf_fill", '{1, 1, 1, 1},
            '{8'h11, 8'h22, 8'h33, 8'h44},
            '{0, 0, 0, 0}, '{0, 0, 0, 0});
    @(negedge clk);
    push_req = 1'b1; push_data = 8'h55;
    #1;
    checks++;
    if (push_gnt !== 1'b0 || ovf_err !== 1'b1) begin
      fails++;
      $display("FAIL ovf_same gnt=%0b ovf=%0b exp 0/1", push_gnt, ovf_err);
    end
    @(posedge clk); #1;
    checks++;
    if (halted !== 1'b1 || ovf_err !== 1'b1 || unf_err !== 1'b0) begin
      fails++;
      $display("FAIL ovf_halt halted=%0b ovf=%0b unf=%0b exp 1/1/0",
               halted, ovf_err, unf_err);
    end
    drive(0, 8'h00, 1, 0, pg, qg);
    checks++;
    if (qg !== 1'b0 || count !== 3'd4 || halted !== 1'b1) begin
      fails++;
      $display("FAIL halt_ignore gnt=%0b count=%0d halted=%0b exp 0/4/1",
               qg, count, halted);
    end
    err_clr = 1'b1;
    drive(0, 8'h00, 0, 0, pg, qg);
    err_clr = 1'b0;
    checks++;
    if (halted !== 1'b0 || ovf_err !== 1'b0 || unf_err !== 1'b0) begin
      fails++;
      $display("FAIL err_clr halted=%0b ovf=%0b unf=%0b exp 0",
               halted, ovf_err, unf_err);
    end
    run_ops("ovf_drain", '{0, 0, 0, 0, 0},
            '{0, 0, 0, 0, 0}, '{1, 1, 1, 1, 0}, '{0, 0, 0, 0, 0});
  endtask

  task automatic test_nonsticky_underflow();
    do_reset();
    @(negedge clk);
    z_push_req = 1'b1; z_push_data = 8'h66;
    z_pop_req = 1'b1; z_pop_mode = 1'b0;
    #1;
    checks++;
    if (z_unf_err !== 1'b1 || z_push_gnt !== 1'b1 || z_pop_gnt !== 1'b0) begin
      fails++;
      $display("FAIL unf_pulse unf=%0b pushg=%0b popg=%0b exp 1/1/0",
               z_unf_err, z_push_gnt, z_pop_gnt);
    end
    @(posedge clk); #1;
    z_push_req = 1'b0; z_pop_req = 1'b0;
    #1;
    checks++;
    if (z_count !== 3'd1 || z_halted !== 1'b0 || z_unf_err !== 1'b0
        || z_ovf_err !== 1'b0 || z_pop_valid !== 1'b0) begin
      fails++;
      $display("FAIL unf_after count=%0d halted=%0b unf=%0b exp 1/0/0",
               z_count, z_halted, z_unf_err);
    end
  endtask

  task automatic test_flush_rst();
    bit pg, qg;
    do_reset();
    run_ops("fl_fill", '{1, 1, 1, 1, 0}, '{8'h31, 8'h32, 8'h33, 8'h34, 0},
            '{0, 0, 0, 0, 1}, '{0, 0, 0, 0, 0});
    flush = 1'b1;
    drive(1, 8'h77, 0, 0, pg, qg);
    flush = 1'b0;
    mq.delete();
    checks++;
    if (pg !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin
      fails++;
      $display("FAIL flush gnt=%0b count=%0d empty=%0b exp 0/0/1",
               pg, count, empty);
    end
    checks++;
    if (pop_valid !== 1'b0 || pop_data !== m_data || halted !== 1'b0) begin
      fails++;
      $display("FAIL flush_hold valid=%0b data=%h halted=%0b exp 0/%h/0",
               pop_valid, pop_data, halted, m_data);
    end
    run_ops("fl_after", '{1, 1, 0, 0}, '{8'h12, 8'h13, 0, 0},
            '{0, 0, 1, 1}, '{0, 0, 1, 0});
    run_ops("rst_fill", '{1, 1}, '{8'h41, 8'h42}, '{0, 0}, '{0, 0});
    rst = 1'b1;
    drive(0, 8'h00, 1, 0, pg, qg);
    rst = 1'b0;
    pop_req = 1'b0;
    mq.delete(); m_last_pop = 1'b1; m_data = 8'h00;
    checks++;
    if (qg !== 1'b0 || pop_valid !== 1'b0 || count !== 3'd0
        || pop_data !== 8'h00) begin
      fails++;
      $display("FAIL rst_mid gnt=%0b valid=%0b count=%0d data=%h exp 0",
               qg, pop_valid, count, pop_data);
    end
  endtask

  // Requests are held until granted; never illegal, so no HALT.
  task automatic test_random();
    bit pp, qp, qm, pg, qg, epg, eqg;
    logic [7:0] pd;
    do_reset();
    pp = 0; qp = 0; qm = 0; pd = 8'h00;
    for (int n = 0; n < 400; n++) begin
      if (!pp) begin
        pp = 1'($urandom) && mq.size() < 4;
        pd = 8'($urandom);
      end
      if (!qp) begin
        qp = 1'($urandom) && mq.size() > 0;
        qm = 1'($urandom);
      end
      model_step(pp, pd, qp, qm, epg, eqg);
      drive(pp, pd, qp, qm, pg, qg);
      checks++;
      if (pg !== epg || qg !== eqg) begin
        fails++;
        $display("FAIL rnd_gnt n%0d got=%0b%0b exp=%0b%0b",
                 n, pg, qg, epg, eqg);
      end
      checks++;
      if (pop_valid !== eqg || pop_data !== m_data
          || count !== 3'(mq.size())) begin
        fails++;
        $display("FAIL rnd_state n%0d v=%0b d=%h c=%0d exp %0b/%h/%0d",
                 n, pop_valid, pop_data, count, eqg, m_data, mq.size());
      end
      if (pg) pp = 0;
      if (qg) qp = 0;
    end
    checks++;
    if (halted !== 1'b0 || ovf_err !== 1'b0 || unf_err !== 1'b0) begin
      fails++;
      $display("FAIL rnd_err halted=%0b ovf=%0b unf=%0b exp 0",
               halted, ovf_err, unf_err);
    end
  endtask

  initial begin
    rst = 1'b1;
    push_req = 1'b0; pop_req = 1'b0; pop_mode = 1'b0;
    push_data = 8'h00; flush = 1'b0; err_clr = 1'b0;
    test_reset();
    test_lifo();
    test_fifo();
    test_back_to_back();
    test_overflow_halt();
    test_nonsticky_underflow();
    test_flush_rst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
